data_mem_arbiter: RTL and testbench

- Shares the single 64-bit data memory port between two requesters: the core datapath (load/store path from the multicycle control FSM) and a loader/debug port used to preload or inspect data memory.
- Sits between the requesters and the data memory instance.
- Serialises accesses, drives one memory write strobe per transaction, and returns read data with a per-requester done pulse.

---
 rtl/data_mem_arbiter.sv | 121 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Two-requester arbiter (core datapath, loader/debug) onto a single data memory port.
// Build option: define DATA_MEM_ARB_RR_EN for round-robin arbitration; otherwise the core has fixed priority.
module data_mem_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_done,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_done,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] LAT_LAST = 4'(MEM_LAT - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic              win;     // 0 = core, 1 = loader
  logic              lat_we;

  logic              pick_l;
  logic              pick_we;
  logic [ADDR_W-1:0] pick_addr;
  logic [DATA_W-1:0] pick_wdata;

`ifdef DATA_MEM_ARB_RR_EN
  logic last_win;  // 0 = core, 1 = loader
  // On a tie the loader wins only when the core was served last.
  assign pick_l = l_req & (~c_req | ~last_win);
`else
  assign pick_l = l_req & ~c_req;
`endif

  assign pick_we    = pick_l ? l_we    : c_we;
  assign pick_addr  = pick_l ? l_addr  : c_addr;
  assign pick_wdata = pick_l ? l_wdata : c_wdata;

  // mem_addr/mem_wdata double as the latched address/data of the winner, so they
  // stay stable for the whole ACCESS phase without a separate copy.
  // NOTE: all state below uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      win       <= 1'b0;
      lat_we    <= 1'b0;
      c_gnt     <= 1'b0;
      c_done    <= 1'b0;
      l_gnt     <= 1'b0;
      l_done    <= 1'b0;
      mem_wr    <= 1'b0;
      busy      <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef DATA_MEM_ARB_RR_EN
      last_win  <= 1'b1;
`endif
    end else begin
      c_gnt  <= 1'b0;
      l_gnt  <= 1'b0;
      c_done <= 1'b0;
      l_done <= 1'b0;
      mem_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (c_req || l_req) begin
            win       <= pick_l;
            lat_we    <= pick_we;
            mem_addr  <= pick_addr;
            mem_wdata <= pick_wdata;
            mem_wr    <= pick_we;
            c_gnt     <= ~pick_l;
            l_gnt     <= pick_l;
            cnt       <= LAT_LAST;
            busy      <= 1'b1;
            state     <= ACCESS;
`ifdef DATA_MEM_ARB_RR_EN
            last_win  <= pick_l;
`endif
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (!lat_we) rdata <= mem_rdata;
            c_done <= ~win;
            l_done <= win;
            state  <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench: lane 0 runs MEM_LAT=1, lane 1 runs MEM_LAT=3, each with its own memory model.
module tb_data_mem_arbiter;

  typedef struct {
    logic        who;      // 0 = core, 1 = loader
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    int          gnt_cyc;
  } item_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]  rst = 2'b11;
  logic [1:0]  c_req = '0, c_we = '0, l_req = '0, l_we = '0;
  logic [63:0] c_addr [2] = '{64'h0, 64'h0};
  logic [63:0] c_wdata[2] = '{64'h0, 64'h0};
  logic [63:0] l_addr [2] = '{64'h0, 64'h0};
  logic [63:0] l_wdata[2] = '{64'h0, 64'h0};
  logic [1:0]  c_gnt, c_done, l_gnt, l_done, mem_wr, busy;
  logic [63:0] rdata[2], mem_addr[2], mem_wdata[2], mem_rdata[2];

  data_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1)) u_dut0 (
    .CLK(clk), .RST(rst[0]),
    .c_req(c_req[0]), .c_we(c_we[0]), .c_addr(c_addr[0]), .c_wdata(c_wdata[0]),
    .c_gnt(c_gnt[0]), .c_done(c_done[0]),
    .l_req(l_req[0]), .l_we(l_we[0]), .l_addr(l_addr[0]), .l_wdata(l_wdata[0]),
    .l_gnt(l_gnt[0]), .l_done(l_done[0]),
    .rdata(rdata[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_wr(mem_wr[0]), .mem_rdata(mem_rdata[0]), .busy(busy[0])
  );

  data_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(3)) u_dut1 (
    .CLK(clk), .RST(rst[1]),
    .c_req(c_req[1]), .c_we(c_we[1]), .c_addr(c_addr[1]), .c_wdata(c_wdata[1]),
    .c_gnt(c_gnt[1]), .c_done(c_done[1]),
    .l_req(l_req[1]), .l_we(l_we[1]), .l_addr(l_addr[1]), .l_wdata(l_wdata[1]),
    .l_gnt(l_gnt[1]), .l_done(l_done[1]),
    .rdata(rdata[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_wr(mem_wr[1]), .mem_rdata(mem_rdata[1]), .busy(busy[1])
  );

  // Memory model: untouched words read back a fixed pattern of their address.
  function automatic logic [63:0] init_val(input logic [7:0] a);
    if (a == 8'h10) return 64'hDEAD_BEEF_0000_0001;
    return {56'h5A5A_0000_0000_00, a};
  endfunction

  logic [63:0] mem [2][256];
  logic        wv  [2][256] = '{default: 1'b0};
  logic [63:0] rd_comb[2];
  logic [63:0] p1, p2;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      rd_comb[k] = wv[k][mem_addr[k][7:0]] ? mem[k][mem_addr[k][7:0]] : init_val(mem_addr[k][7:0]);
    end
  end

  always @(posedge clk) begin
    p1 <= rd_comb[1];
    p2 <= p1;
    for (int k = 0; k < 2; k++) begin
      if (mem_wr[k]) begin
        mem[k][mem_addr[k][7:0]] <= mem_wdata[k];
        wv[k][mem_addr[k][7:0]]  <= 1'b1;
      end
    end
  end

  assign mem_rdata[0] = rd_comb[0];
  assign mem_rdata[1] = p2;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lat(input int ln);
    return (ln == 0) ? 1 : 3;
  endfunction

  item_t q0[$], q1[$];

  function automatic int qsize(input int ln);
    if (ln == 0) return q0.size();
    return q1.size();
  endfunction

  function automatic item_t qfront(input int ln);
    if (ln == 0) return q0[0];
    return q1[0];
  endfunction

  task automatic qpush(input int ln, input item_t it);
    if (ln == 0) q0.push_back(it);
    else q1.push_back(it);
  endtask

  task automatic qpop(input int ln);
    if (ln == 0) void'(q0.pop_front());
    else void'(q1.pop_front());
  endtask

  function automatic item_t mk(input logic who, input logic we, input logic [63:0] addr,
                               input logic [63:0] wdata, input logic [63:0] rd, input int gc);
    item_t it;
    it.who = who; it.we = we; it.addr = addr; it.wdata = wdata; it.rdata = rd; it.gnt_cyc = gc;
    return it;
  endfunction

  // Monitor: matches each grant and done pulse against the head of the lane's queue.
  logic infl[2]     = '{1'b0, 1'b0};
  logic chk_idle[2] = '{1'b0, 1'b0};
  int   wrc[2]      = '{0, 0};

  task automatic mon(input int ln);
    item_t it;
    if (rst[ln]) begin
      if (infl[ln]) qpop(ln);
      infl[ln] = 1'b0;
      chk_idle[ln] = 1'b0;
      return;
    end
    if (chk_idle[ln]) begin
      chk_idle[ln] = 1'b0;
      check("idle_after_done", {busy[ln], c_gnt[ln], l_gnt[ln]}, 3'b000);
    end
    if (infl[ln] && mem_wr[ln]) wrc[ln]++;
    if (c_gnt[ln] || l_gnt[ln]) begin
      check("gnt_expected", {qsize(ln) > 0, infl[ln]}, 2'b10);
      if (qsize(ln) > 0 && !infl[ln]) begin
        it = qfront(ln);
        infl[ln] = 1'b1;
        wrc[ln] = int'(mem_wr[ln]);
        check("gnt_who", {l_gnt[ln], c_gnt[ln]}, it.who ? 2'b10 : 2'b01);
        check("gnt_cycle", cyc, it.gnt_cyc);
        check("gnt_busy", busy[ln], 1'b1);
        check("gnt_mem_addr", {mem_wr[ln], mem_addr[ln]}, {it.we, it.addr});
        if (it.we) check("gnt_mem_wdata", mem_wdata[ln], it.wdata);
      end
    end
    if (c_done[ln] || l_done[ln]) begin
      check("done_in_flight", infl[ln], 1'b1);
      if (infl[ln]) begin
        it = qfront(ln);
        qpop(ln);
        infl[ln] = 1'b0;
        check("done_who", {l_done[ln], c_done[ln]}, it.who ? 2'b10 : 2'b01);
        check("done_cycle", cyc, it.gnt_cyc + lat(ln));
        check("done_rdata", rdata[ln], it.rdata);
        check("done_wr_count", wrc[ln], int'(it.we));
        check("done_busy", busy[ln], 1'b1);
        chk_idle[ln] = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic reset_chk(input int ln);
    check("rst_ctrl", {c_gnt[ln], c_done[ln], l_gnt[ln], l_done[ln], mem_wr[ln], busy[ln]}, 6'b0);
    check("rst_rdata", rdata[ln], 64'h0);
    check("rst_mem_bus", {mem_addr[ln], mem_wdata[ln]}, 128'h0);
  endtask

  task automatic wait_gnt(input int ln, input logic who);
    logic seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = who ? l_gnt[ln] : c_gnt[ln];
    end
    check("gnt_seen", seen, 1'b1);
  endtask

  // Single transaction on one requester; req is dropped on grant.
  task automatic issue(input int ln, input logic who, input logic we, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [63:0] rd);
    qpush(ln, mk(who, we, addr, wdata, rd, cyc + 1));
    if (!who) begin
      c_req[ln] = 1'b1; c_we[ln] = we; c_addr[ln] = addr; c_wdata[ln] = wdata;
    end else begin
      l_req[ln] = 1'b1; l_we[ln] = we; l_addr[ln] = addr; l_wdata[ln] = wdata;
    end
    wait_gnt(ln, who);
    c_req[ln] = 1'b0;
    l_req[ln] = 1'b0;
    repeat (lat(ln) + 1) @(negedge clk);
  endtask

  // Both requesters read, each holding req until it has received its grant count.
  task automatic dual(input int ln, input int nc, input int nl, input logic [63:0] cb, input logic [63:0] lb);
    int gc = 0;
    int gl = 0;
    c_we[ln] = 1'b0; l_we[ln] = 1'b0;
    c_addr[ln] = cb; l_addr[ln] = lb;
    c_req[ln] = (nc > 0); l_req[ln] = (nl > 0);
    for (int i = 0; i < 100 && (gc < nc || gl < nl); i++) begin
      @(negedge clk);
      if (c_gnt[ln]) begin
        gc++;
        if (gc >= nc) c_req[ln] = 1'b0;
        else c_addr[ln] = cb + 64'(gc);
      end
      if (l_gnt[ln]) begin
        gl++;
        if (gl >= nl) l_req[ln] = 1'b0;
        else l_addr[ln] = lb + 64'(gl);
      end
    end
    check("dual_grants", {gc, gl}, {nc, nl});
    repeat (lat(ln) + 1) @(negedge clk);
  endtask

  initial begin
    int c;
    repeat (3) @(negedge clk);
    reset_chk(0);
    reset_chk(1);
    rst = 2'b00;
    @(negedge clk);

    // Lane 0, MEM_LAT=1.
    issue(0, 1'b0, 1'b0, 64'h10, 64'h0, 64'hDEAD_BEEF_0000_0001);
    issue(0, 1'b1, 1'b1, 64'h20, 64'h1234, 64'hDEAD_BEEF_0000_0001);
    issue(0, 1'b0, 1'b0, 64'h20, 64'h0, 64'h1234);
    c = cyc;
`ifdef DATA_MEM_ARB_RR_EN
    qpush(0, mk(1'b1, 1'b0, 64'h12, 64'h0, 64'h5A5A_0000_0000_0012, c + 1));
    qpush(0, mk(1'b0, 1'b0, 64'h11, 64'h0, 64'h5A5A_0000_0000_0011, c + 4));
`else
    qpush(0, mk(1'b0, 1'b0, 64'h11, 64'h0, 64'h5A5A_0000_0000_0011, c + 1));
    qpush(0, mk(1'b1, 1'b0, 64'h12, 64'h0, 64'h5A5A_0000_0000_0012, c + 4));
`endif
    dual(0, 1, 1, 64'h11, 64'h12);

    // Lane 1, MEM_LAT=3: both held for four transactions, then latency and reset cases.
    c = cyc;
`ifdef DATA_MEM_ARB_RR_EN
    qpush(1, mk(1'b0, 1'b0, 64'h30, 64'h0, 64'h5A5A_0000_0000_0030, c + 1));
    qpush(1, mk(1'b1, 1'b0, 64'h40, 64'h0, 64'h5A5A_0000_0000_0040, c + 6));
    qpush(1, mk(1'b0, 1'b0, 64'h31, 64'h0, 64'h5A5A_0000_0000_0031, c + 11));
    qpush(1, mk(1'b1, 1'b0, 64'h41, 64'h0, 64'h5A5A_0000_0000_0041, c + 16));
`else
    qpush(1, mk(1'b0, 1'b0, 64'h30, 64'h0, 64'h5A5A_0000_0000_0030, c + 1));
    qpush(1, mk(1'b0, 1'b0, 64'h31, 64'h0, 64'h5A5A_0000_0000_0031, c + 6));
    qpush(1, mk(1'b1, 1'b0, 64'h40, 64'h0, 64'h5A5A_0000_0000_0040, c + 11));
    qpush(1, mk(1'b1, 1'b0, 64'h41, 64'h0, 64'h5A5A_0000_0000_0041, c + 16));
`endif
    dual(1, 2, 2, 64'h30, 64'h40);
    issue(1, 1'b0, 1'b0, 64'h08, 64'h0, 64'h5A5A_0000_0000_0008);

    qpush(1, mk(1'b0, 1'b0, 64'h50, 64'h0, 64'h5A5A_0000_0000_0050, cyc + 1));
    c_req[1] = 1'b1; c_we[1] = 1'b0; c_addr[1] = 64'h50;
    wait_gnt(1, 1'b0);
    c_req[1] = 1'b0;
    @(posedge clk);
    #2 rst[1] = 1'b1;
    #1 reset_chk(1);
    repeat (3) @(negedge clk);
    rst[1] = 1'b0;
    repeat (6) @(negedge clk);
    issue(1, 1'b0, 1'b0, 64'h09, 64'h0, 64'h5A5A_0000_0000_0009);

    repeat (4) @(negedge clk);
    check("q0_drained", qsize(0), 0);
    check("q1_drained", qsize(1), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
